// File: rtl/updi_instruction_sequencer.sv
// Sequences one UPDI instruction: SYNCH, opcode and operand bytes to the TX FIFO,
// then steers updi_input_handler through the response/ACK phase and reports status.
module updi_instruction_sequencer #(
  parameter int unsigned BITS_N     = 6,
  parameter logic [7:0]  SYNCH_BYTE = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_opcode,
  input  logic [BITS_N-1:0] cmd_n_operands,
  input  logic [BITS_N-1:0] cmd_n_rx,
  input  logic              cmd_wait_ack,
  input  logic [7:0]        op_data,
  input  logic              op_empty,
  output logic              op_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_full,
  input  logic              tx_idle,
  output logic [BITS_N-1:0] ih_n_bytes,
  output logic              ih_start,
  output logic              ih_wait_ack,
  input  logic              ih_ready,
  input  logic              ih_done,
  input  logic              ih_timeout,
  input  logic              ih_ack_received,
  input  logic              ih_ack_error,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_OPCODE, S_OP_POP, S_OP_PUSH, S_DRAIN,
    S_RX_START, S_RX_WAIT, S_ACK_START, S_ACK_WAIT, S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [7:0]        opcode_q;
  logic [7:0]        op_q;
  logic [BITS_N-1:0] ops_q;
  logic [BITS_N-1:0] rx_q;
  logic              wack_q;
  logic              pop_q;
  logic              err_to_q;
  logic              err_ack_q;

  logic              accept;
  logic              ops_dec;
  logic              set_to;
  logic              set_ack;

  // op_data is only guaranteed the cycle after a pop; a tx_full stall then uses the copy.
  logic [7:0] op_byte;
  assign op_byte = pop_q ? op_data : op_q;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FINISH);
  assign ih_n_bytes  = rx_q;
  assign err_timeout = err_to_q;
  assign err_ack     = err_ack_q;

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    ops_dec     = 1'b0;
    set_to      = 1'b0;
    set_ack     = 1'b0;
    tx_data     = '0;
    tx_wr_en    = 1'b0;
    op_rd_en    = 1'b0;
    ih_start    = 1'b0;
    ih_wait_ack = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!tx_full) begin
          tx_data  = SYNCH_BYTE;
          tx_wr_en = 1'b1;
          state_nx = S_OPCODE;
        end
      end
      S_OPCODE: begin
        if (!tx_full) begin
          tx_data  = opcode_q;
          tx_wr_en = 1'b1;
          state_nx = (ops_q != '0) ? S_OP_POP : S_DRAIN;
        end
      end
      S_OP_POP: begin
        if (!op_empty) begin
          op_rd_en = 1'b1;
          state_nx = S_OP_PUSH;
        end
      end
      S_OP_PUSH: begin
        if (!tx_full) begin
          tx_data  = op_byte;
          tx_wr_en = 1'b1;
          ops_dec  = 1'b1;
          state_nx = (ops_q != BITS_N'(1)) ? S_OP_POP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tx_idle) begin
          if (rx_q != '0)  state_nx = S_RX_START;
          else if (wack_q) state_nx = S_ACK_START;
          else             state_nx = S_FINISH;
        end
      end
      S_RX_START: begin
        if (ih_ready) begin
          ih_start = 1'b1;
          state_nx = S_RX_WAIT;
        end
      end
      S_RX_WAIT: begin
        if (ih_timeout) begin
          set_to   = 1'b1;
          state_nx = S_FINISH;
        end else if (ih_ready) begin
          state_nx = wack_q ? S_ACK_START : S_FINISH;
        end
      end
      S_ACK_START: begin
        if (ih_ready) begin
          ih_wait_ack = 1'b1;
          state_nx    = S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: begin
        if (ih_ack_received) begin
          set_ack  = 1'b1;
          state_nx = S_FINISH;
        end else if (ih_timeout) begin
          set_to   = 1'b1;
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      opcode_q  <= '0;
      op_q      <= '0;
      ops_q     <= '0;
      rx_q      <= '0;
      wack_q    <= 1'b0;
      pop_q     <= 1'b0;
      err_to_q  <= 1'b0;
      err_ack_q <= 1'b0;
    end else begin
      state <= state_nx;
      pop_q <= op_rd_en;
      if (pop_q) op_q <= op_data;
      if (accept) begin
        opcode_q  <= cmd_opcode;
        ops_q     <= cmd_n_operands;
        rx_q      <= cmd_n_rx;
        wack_q    <= cmd_wait_ack;
        err_to_q  <= 1'b0;
        err_ack_q <= 1'b0;
      end
      if (ops_dec) ops_q <= ops_q - BITS_N'(1);
      if (set_to)  err_to_q <= 1'b1;
      if (set_ack) err_ack_q <= ih_ack_error;
    end
  end

  logic unused_ok;
  assign unused_ok = ih_done;

endmodule

// File: tb/tb_updi_instruction_sequencer.sv
// Scoreboard bench for updi_instruction_sequencer with behavioural TX FIFO,
// operand FIFO and input-handler models.
module tb_updi_instruction_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_opcode = '0;
  logic [5:0] cmd_n_operands = '0;
  logic [5:0] cmd_n_rx = '0;
  logic       cmd_wait_ack = 1'b0;
  logic [7:0] op_data = '0;
  logic       op_empty;
  logic       op_rd_en;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_full = 1'b0;
  logic       tx_idle;
  logic [5:0] ih_n_bytes;
  logic       ih_start;
  logic       ih_wait_ack;
  logic       ih_ready = 1'b1;
  logic       ih_done = 1'b0;
  logic       ih_timeout = 1'b0;
  logic       ih_ack_received = 1'b0;
  logic       ih_ack_error = 1'b0;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_ack;

  updi_instruction_sequencer #(.BITS_N(6), .SYNCH_BYTE(8'h55)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_n_operands(cmd_n_operands), .cmd_n_rx(cmd_n_rx), .cmd_wait_ack(cmd_wait_ack),
    .op_data(op_data), .op_empty(op_empty), .op_rd_en(op_rd_en),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_idle(tx_idle),
    .ih_n_bytes(ih_n_bytes), .ih_start(ih_start), .ih_wait_ack(ih_wait_ack),
    .ih_ready(ih_ready), .ih_done(ih_done), .ih_timeout(ih_timeout),
    .ih_ack_received(ih_ack_received), .ih_ack_error(ih_ack_error),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // TX FIFO model: idle 3 cycles after the last push
  int tx_cnt = 0;
  assign tx_idle = (tx_cnt == 0);
  always @(posedge clk) begin
    if (tx_wr_en && !tx_full) tx_cnt <= 3;
    else if (tx_cnt != 0)     tx_cnt <= tx_cnt - 1;
  end

  // Operand FIFO model
  logic [7:0] op_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic op_hold = 1'b0;
  assign op_empty = (wr_ptr == rd_ptr) || op_hold;
  always @(posedge clk) begin
    if (op_rd_en) begin
      op_data <= op_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Input handler model
  bit cfg_timeout = 1'b0;
  bit cfg_ack_err = 1'b0;
  int hcnt = 0;
  int hmode = 0;
  always @(posedge clk) begin
    ih_timeout      <= 1'b0;
    ih_ack_received <= 1'b0;
    ih_ack_error    <= 1'b0;
    ih_done         <= 1'b0;
    if (rst) begin
      ih_ready <= 1'b1;
      hcnt     <= 0;
    end else if (ih_start) begin
      ih_ready <= 1'b0;
      hcnt     <= 4;
      hmode    <= 1;
    end else if (ih_wait_ack) begin
      ih_ready <= 1'b0;
      hcnt     <= 3;
      hmode    <= 2;
    end else if (hcnt != 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) begin
        ih_ready <= 1'b1;
        if (hmode == 1) begin
          if (cfg_timeout) ih_timeout <= 1'b1;
          else             ih_done <= 1'b1;
        end else begin
          ih_ack_received <= 1'b1;
          ih_ack_error    <= cfg_ack_err;
        end
      end
    end
  end

  // Scoreboard queues and monitor
  logic [7:0] exp_tx[$];
  int         exp_ihn[$];
  logic [1:0] exp_done[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  int ack_pulses = 0;
  bit prev_idle = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_wr_en) begin
        if (exp_tx.size() == 0) check("tx_unexpected_push", tx_data, 'h100);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (ih_start) begin
        if (exp_ihn.size() == 0) check("ih_start_unexpected", 1, 0);
        else check("ih_n_bytes", ih_n_bytes, exp_ihn.pop_front());
      end
      if (ih_wait_ack) ack_pulses++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else check("done_err_flags", {err_timeout, err_ack}, exp_done.pop_front());
      end
      if (tx_idle && !prev_idle) rise_cyc = cyc;
    end
    prev_idle = tx_idle;
  end

  task automatic issue(input logic [7:0] opc, input int nops, input int nrx, input bit wack);
    @(negedge clk);
    cmd_opcode     = opc;
    cmd_n_operands = 6'(nops);
    cmd_n_rx       = 6'(nrx);
    cmd_wait_ack   = wack;
    cmd_valid      = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    check("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] opc, input int nops, input int nrx, input bit wack,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input bit to, input bit ae, input string tag);
    logic [7:0] b [3];
    int start_done;
    int k;
    b[0] = b0; b[1] = b1; b[2] = b2;
    start_done  = done_cnt;
    ack_pulses  = 0;
    cfg_timeout = to;
    cfg_ack_err = ae;
    exp_tx.push_back(8'h55);
    exp_tx.push_back(opc);
    for (int i = 0; i < nops; i++) begin
      op_mem[wr_ptr % 64] = b[i];
      wr_ptr++;
      exp_tx.push_back(b[i]);
    end
    if (nrx != 0) exp_ihn.push_back(nrx);
    exp_done.push_back({to, ae && wack && !to});
    issue(opc, nops, nrx, wack);
    for (k = 0; k < 400 && done_cnt == start_done; k++) @(posedge clk);
    check({tag, "_done_seen"}, done_cnt - start_done, 1);
    #1;
    check({tag, "_cmd_ready_after_done"}, cmd_ready, 1);
    check({tag, "_tx_bytes_left"}, exp_tx.size(), 0);
    check({tag, "_ih_start_left"}, exp_ihn.size(), 0);
    check({tag, "_wait_ack_pulses"}, ack_pulses, (wack && !to) ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_wr_en"}, tx_wr_en, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_op_rd_en"}, op_rd_en, 0);
    check({tag, "_ih_start"}, ih_start, 0);
    check({tag, "_ih_wait_ack"}, ih_wait_ack, 0);
    check({tag, "_ih_n_bytes"}, ih_n_bytes, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_err_ack"}, err_ack, 0);
  endtask

  initial begin
    int start_done;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // LDCS, one response byte
    run_cmd(8'h80, 0, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "ldcs");

    // STS with three operands and ACK, good then bad ACK
    run_cmd(8'h44, 3, 0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, "sts_ack_ok");
    run_cmd(8'h44, 3, 0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1, "sts_ack_err");

    // Back-pressure on TX during OPCODE and on the operand FIFO before operand 2
    fork
      run_cmd(8'h44, 3, 0, 1'b1, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, "backpressure");
      begin
        for (int k = 0; k < 50 && !(tx_wr_en && tx_data == 8'h55); k++) @(negedge clk);
        @(posedge clk);
        #1 tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_full = 1'b0;
        for (int k = 0; k < 50 && !op_rd_en; k++) @(negedge clk);
        @(posedge clk);
        #1 op_hold = 1'b1;
        repeat (4) @(posedge clk);
        #1 op_hold = 1'b0;
      end
    join

    // Response timeout skips the ACK phase
    run_cmd(8'h24, 0, 2, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, "timeout");
    cfg_timeout = 1'b0;

    // Reset while stalled in OP_PUSH
    start_done = done_cnt;
    op_mem[wr_ptr % 64] = 8'hA1; wr_ptr++;
    op_mem[wr_ptr % 64] = 8'hA2; wr_ptr++;
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h64);
    issue(8'h64, 2, 0, 1'b0);
    for (int k = 0; k < 50 && !op_rd_en; k++) @(negedge clk);
    check("midrst_pop_seen", op_rd_en, 1);
    @(posedge clk);
    #1 tx_full = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    check("midrst_tx_bytes", exp_tx.size(), 0);
    check("midrst_no_done", done_cnt - start_done, 0);
    @(negedge clk);
    rst = 1'b0;
    tx_full = 1'b0;
    wr_ptr = rd_ptr;
    exp_tx.delete();
    exp_ihn.delete();
    exp_done.delete();

    run_cmd(8'h80, 0, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "after_reset");

    // Zero-length command and its completion latency
    run_cmd(8'hC5, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "zero_len");
    check("zero_len_latency", done_cyc - rise_cyc, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
